hd6309_dma_arb: RTL
===================

Name: hd6309_dma_arb

Overview:
- Bus arbiter that shares the HD6309 external bus between the CPU core and N DMA requesters.
- Sequences the core's nDMABREQ input and watches the BA/BS bus-grant status.
- Grants one requester at a time (round-robin), bounds each burst, and forces CPU hold-off slots between bursts so the core always makes progress.
- Sits beside the CPU core. Its output nDMABREQ drives the core input that is otherwise tied high.

Parameters:
- NREQ, 4, number of DMA requesters (2..8).
- MAX_BURST, 14, maximum E cycles one requester may own the bus per grant (1..15). Stays below the core's internal 15-cycle DMA refresh limit.
- CPU_SLOTS, 2, E cycles the CPU keeps the bus after a release before a new request is raised (>=1).
- TIMEOUT, 64, E cycles to wait for BA&BS after nDMABREQ falls before flagging an error.

Ports:
- E  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous reset, active-high.
- REQ  input  NREQ  per-requester bus request; level, held until done.
- BA  input  1  core bus-available status.
- BS  input  1  core bus-status; BA&BS=1 means bus granted.
- nDMABREQ  output  1  DMA/bus request to the core, active-low.
- GNT  output  NREQ  one-hot grant to the requester owning the bus.
- GNT_ID  output  3  encoded index of the current or last winner.
- BUSOWN  output  1  1 while a requester drives the bus (external address/data mux select).
- ERR  output  1  sticky timeout flag; cleared only by RESET.

Behaviour:
- All outputs registered.
- Reset values: nDMABREQ=1, GNT=0, GNT_ID=0, BUSOWN=0, ERR=0. State=IDLE, round-robin pointer=0, counters=0.
- RESET mid-operation: everything returns to reset values on the next edge, even if a grant is active. The core is free to resume immediately.
- States: IDLE, REQUEST, GRANT, RELEASE, HOLDOFF.
- IDLE:
  - If REQ!=0, pick the first asserted bit at or after the pointer (wrap modulo NREQ) and latch it as the winner into GNT_ID.
  - Drive nDMABREQ=0 and go to REQUEST.
  - REQ arriving in any other state waits.
- REQUEST:
  - Timeout counter increments each cycle.
  - If BA&BS is sampled 1, go to GRANT: GNT[winner]=1 and BUSOWN=1 on that edge. Pointer becomes (winner+1) mod NREQ. Burst counter is loaded with 1.
  - If REQ[winner] drops before the grant (abort): nDMABREQ=1, go to RELEASE, no GNT pulse.
  - If the counter reaches TIMEOUT: set ERR=1, nDMABREQ=1, go to RELEASE.
  - The abort check has priority over the timeout check.
- GRANT:
  - Burst counter increments each cycle.
  - Leave when REQ[winner]=0, or when the counter reaches MAX_BURST. If both happen in the same cycle, there is a single exit.
  - On exit: GNT=0, BUSOWN=0, nDMABREQ=1 on the same edge. Go to RELEASE.
  - Bus ownership lasts at most MAX_BURST cycles.
  - If BA&BS drops unexpectedly during GRANT (e.g. core refresh), release immediately.
- RELEASE:
  - Wait until BA is sampled 0, meaning the CPU has the bus back.
  - Then load the hold-off counter and go to HOLDOFF.
- HOLDOFF:
  - Count CPU_SLOTS cycles, then go to IDLE.
  - REQ is ignored during HOLDOFF, even if the same requester is still asserting.
- Latency: REQ high to nDMABREQ low = 1 edge. BA&BS sampled high to GNT high = 1 edge. REQ low to GNT low = 1 edge.
- Only one GNT bit is ever high. GNT!=0 implies BUSOWN=1 and nDMABREQ=0.
- A burst that hits MAX_BURST while its REQ stays high re-competes after HOLDOFF. Round-robin gives other requesters priority first.
- Counter widths: clog2(TIMEOUT+1) and 4 bits; no wrap (they saturate at their limits).

Decomposition:
- Shared package hd6309_pkg holds:
  - the arbiter state enum;
  - the BUS_GRANTED constant pair for BA/BS (BA=1, BS=1);
  - the localparam limit DMA_REFRESH_LIMIT=15, against which MAX_BURST is checked with an elaboration assertion.
- One natural sub-module: hd6309_rr_pick, a combinational round-robin priority selector. Inputs: REQ vector and pointer. Outputs: winner index and a valid flag.

Test Plan:
- NREQ=4, REQ=0100 in IDLE, BA/BS go high 3 cycles after nDMABREQ falls -> nDMABREQ low 1 cycle after REQ; GNT=0100 and GNT_ID=2 1 cycle after BA&BS; REQ drop after 5 cycles -> GNT=0 and nDMABREQ=1 next edge; BA low -> HOLDOFF 2 cycles -> IDLE.
- REQ=1111 held continuously -> grants in order 0,1,2,3,0; every burst exactly 14 cycles; at least 2 CPU cycles with BA=0 between bursts.
- REQ[1] asserted, BA/BS never rise -> ERR=1 after 64 cycles, nDMABREQ=1, GNT never asserted; ERR stays 1 until RESET.
- REQ[3] drops while in REQUEST -> no GNT pulse, nDMABREQ returns to 1, next winner taken from pointer 0.
- RESET asserted during GRANT at burst cycle 7 -> next edge GNT=0, BUSOWN=0, nDMABREQ=1, state IDLE, pointer 0.
- BA&BS drop mid-GRANT -> GNT=0 next edge, RELEASE, then HOLDOFF before any new grant.

Source files
------------

// File: rtl/hd6309_pkg.sv
// Shared types and constants for the HD6309 DMA bus arbiter.
package hd6309_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_GRANT,
    ST_RELEASE,
    ST_HOLDOFF
  } arb_state_e;

  // {BA, BS} value meaning the core has handed the bus over.
  localparam logic [1:0] BUS_GRANTED = 2'b11;

  // Core's internal DMA cycle limit before it forces a refresh.
  localparam int unsigned DMA_REFRESH_LIMIT = 15;

endpackage

// File: rtl/hd6309_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr.
module hd6309_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      idx,
  output logic            valid
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] j;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = IW'((32'(ptr) + i) % NREQ);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = 3'(j);
      end
    end
  end

endmodule

// File: rtl/hd6309_dma_arb.sv
// Round-robin DMA bus arbiter for the HD6309: drives nDMABREQ, bounds bursts,
// and inserts CPU hold-off slots between bursts.
module hd6309_dma_arb
  import hd6309_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 14,
  parameter int unsigned CPU_SLOTS = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic            E,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic            BA,
  input  logic            BS,
  output logic            nDMABREQ,
  output logic [NREQ-1:0] GNT,
  output logic [2:0]      GNT_ID,
  output logic            BUSOWN,
  output logic            ERR
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = $clog2(CPU_SLOTS + 1);

  if (MAX_BURST < 1 || MAX_BURST > DMA_REFRESH_LIMIT) begin : g_burst_chk
    $error("MAX_BURST must be within 1..DMA_REFRESH_LIMIT");
  end

  arb_state_e    state;
  logic [2:0]    ptr;
  logic [TW-1:0] tcnt;
  logic [3:0]    bcnt;
  logic [HW-1:0] hcnt;

  logic [2:0] pick_idx;
  logic       pick_valid;
  logic       granted;
  logic       win_req;

  hd6309_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign granted = ({BA, BS} == BUS_GRANTED);

  always_comb begin
    win_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GNT_ID == 3'(i)) win_req = REQ[i];
    end
  end

  always_ff @(posedge E) begin
    if (RESET) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      tcnt     <= '0;
      bcnt     <= '0;
      hcnt     <= '0;
      nDMABREQ <= 1'b1;
      GNT      <= '0;
      GNT_ID   <= '0;
      BUSOWN   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            GNT_ID   <= pick_idx;
            nDMABREQ <= 1'b0;
            tcnt     <= '0;
            state    <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          // Abort wins over grant and timeout so a withdrawn request never sees GNT.
          if (!win_req) begin
            nDMABREQ <= 1'b1;
            state    <= ST_RELEASE;
          end else if (granted) begin
            GNT    <= NREQ'(1) << GNT_ID;
            BUSOWN <= 1'b1;
            ptr    <= (GNT_ID == 3'(NREQ - 1)) ? 3'd0 : GNT_ID + 3'd1;
            bcnt   <= 4'd1;
            state  <= ST_GRANT;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            ERR      <= 1'b1;
            nDMABREQ <= 1'b1;
            tcnt     <= TW'(TIMEOUT);
            state    <= ST_RELEASE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_GRANT: begin
          if (!win_req || !granted || bcnt >= 4'(MAX_BURST)) begin
            GNT      <= '0;
            BUSOWN   <= 1'b0;
            nDMABREQ <= 1'b1;
            state    <= ST_RELEASE;
          end else begin
            bcnt <= bcnt + 4'd1;
          end
        end
        ST_RELEASE: begin
          if (!BA) begin
            hcnt  <= '0;
            state <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hcnt == HW'(CPU_SLOTS - 1)) state <= ST_IDLE;
          else                            hcnt  <= hcnt + HW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
